mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the 32-bit ALU-source select mux:
  - operand a comes from the rs read port;
  - operand b comes from the mux output.
- Executes MULT/MULTU/DIV/DIVU in 32 iterations and holds results in HI/LO for mfhi/mflo.
- Supports mthi/mtlo writes; exposes busy so the controller can stall.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is required to be supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled on a clk edge while busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  32  rs operand (multiplicand / dividend).
- b  input  32  operand from the ALU-source mux (multiplier / divisor).
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  32  data for mthi/mtlo.
- hi  output  32  HI register (remainder / product upper word).
- lo  output  32  LO register (quotient / product lower word).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the result is written.
- div_by_zero  output  1  set with done when DIV/DIVU had b=0.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE;
  - hi=lo=0;
  - busy=done=div_by_zero=0;
  - iteration counter=0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever written.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1: latch op, latch |a| and |b| (signed ops only; unsigned ops use raw values), record the sign of a and of b, clear the accumulator, counter=0, go to RUN. busy=1 from this edge.
  - start has priority over mthi/mtlo in the same cycle; the mthi/mtlo write is dropped.
  - Without start, mthi/mtlo write hi/lo on the edge. mthi and mtlo together write both.
- RUN:
  - One iteration per cycle; counter increments.
  - After the 32nd RUN cycle (counter=31), go to FIX.
  - Multiply is shift-add into a 64-bit product.
  - Divide is restoring: 64-bit {remainder, quotient} shift, subtract-if-no-borrow.
- FIX:
  - Sign correction.
  - MULT: negate the 64-bit product if sign(a)!=sign(b).
  - DIV: negate the quotient if signs differ; the remainder takes the sign of a.
  - On the FIX exit edge:
    - multiply writes hi=product[63:32], lo=product[31:0];
    - divide writes hi=remainder, lo=quotient;
    - then go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: busy is high for exactly 33 cycles after the start edge. done is high in the 34th cycle after the start edge, the same cycle busy first reads 0.
- A new start may be accepted in the done cycle.
- start, mthi and mtlo while busy=1 are ignored.
- Operands are latched at start; a and b may change afterwards without effect.
- Divide by zero (DIV/DIVU with b=0 at start):
  - full 33-cycle latency is kept;
  - hi and lo are left unchanged;
  - div_by_zero=1 together with done;
  - div_by_zero clears on the next start or reset.
- -2^31 / -1 (DIV): lo=0x80000000, hi=0. No trap.
- hi and lo change only on a reset, an mthi/mtlo write in IDLE, or the FIX exit edge.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; done on cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divides:
  - DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo wdata=0x1234, then DIV a=9, b=0 -> hi/lo unchanged (lo=0x1234), div_by_zero=1 with done; next MULTU 2x3 clears div_by_zero and gives lo=6.
- Ignored requests:
  - start with new operands while busy -> ignored; the first result is unchanged and done pulses once.
  - mthi while busy -> ignored.
  - start+mthi in the same idle cycle -> only the operation runs.
- Assert reset 10 cycles into MULTU 7x9 -> busy=0, hi=lo=0 immediately, no done pulse; after release, MULTU 7x9 gives lo=63.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative 32-cycle HI/LO multiply/divide unit (MULT/MULTU/
//                 DIV/DIVU, mthi/mtlo) with busy/done handshake.
// Revision 1.0
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dbz;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_top;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_step = {add_sum, acc[WIDTH-1:1]};

    // Divide: trial-subtract the divisor from the shifted remainder; keep it only if no borrow.
    assign div_top  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = {1'b0, div_top} - {2'b00, opnd};
    assign div_step = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        count       <= '0;
                        is_div      <= op[1];
                        neg_q       <= sign_a ^ sign_b;
                        neg_r       <= sign_a;
                        dbz         <= op[1] && (b == '0);
                        if (op[1]) begin
                            opnd <= mag_b;
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opnd <= mag_a;
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_step : mul_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        if (dbz) begin
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : directed + randomized checks of mult_div_unit against an
//                    arithmetic reference model.  Revision 1.0
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dbz;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero like MIPS.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] t, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m_dbz = 1'b0;
        case (o)
            2'd0: begin t = {32'd0, x} * {32'd0, y}; m_hi = t[63:32]; m_lo = t[31:0]; end
            2'd1: begin t = sx * sy; m_hi = t[63:32]; m_lo = t[31:0]; end
            2'd2: if (y == 0) m_dbz = 1'b1; else begin m_lo = x / y; m_hi = x % y; end
            default: if (y == 0) m_dbz = 1'b1;
                     else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (34th after start).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb, input bit with_mthi);
        bit          win_ok;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        op = o; a = x; b = y; start = 1'b1;
        if (with_mthi) begin mthi = 1'b1; wdata = $urandom; end
        model(o, x, y);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        win_ok = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hi !== old_hi || lo !== old_lo) win_ok = 1'b0;
            a = $urandom; b = $urandom; op = 2'($urandom);
            if (disturb && i == 5) begin start = 1'b1; mthi = 1'b1; wdata = $urandom; end
            else begin start = 1'b0; mthi = 1'b0; end
            @(negedge clk);
        end
        check({tag, ".busy_window"}, win_ok, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 1);
        check({tag, ".dbz"}, div_by_zero, m_dbz);
        check({tag, ".hi"}, hi, m_hi);
        check({tag, ".lo"}, lo, m_lo);
    endtask

    initial begin
        bit          saw_done;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        #12;
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.dbz", div_by_zero, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max.hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max.lo_const", lo, 32'h0000_0001);
        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0);
        check("mult_neg.lo_const", lo, 32'hFFFF_FFF1);
        run_op("divu", 2'd2, 32'd100, 32'd7, 0, 0);
        check("divu.lo_const", lo, 32'h0000_000E);
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg.hi_const", hi, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf.lo_const", lo, 32'h8000_0000);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_AAAA;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = 32'h5555_AAAA; m_lo = 32'h5555_AAAA;
        check("mthilo.hi", hi, m_hi);
        check("mthilo.lo", lo, m_lo);
        mtlo = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mtlo = 1'b0;
        m_lo = 32'h0000_1234;
        check("mtlo.lo", lo, m_lo);
        check("mtlo.hi", hi, m_hi);

        run_op("div0", 2'd3, 32'd9, 32'd0, 0, 0);
        check("div0.lo_const", lo, 32'h0000_1234);
        run_op("multu_clr", 2'd0, 32'd2, 32'd3, 0, 0);
        check("multu_clr.lo_const", lo, 32'd6);
        run_op("busy_ignored", 2'd1, 32'h1234_5678, 32'h8765_4321, 1, 0);
        run_op("start_mthi", 2'd2, 32'hDEAD_BEEF, 32'd13, 0, 1);

        // Abort a MULTU 7x9 with reset ten cycles in.
        op = 2'd0; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.hi", hi, 0);
        check("abort.lo", lo, 0);
        check("abort.done", done, 0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk); reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort.no_done", saw_done, 0);
        run_op("after_reset", 2'd0, 32'd7, 32'd9, 0, 0);
        check("after_reset.lo_const", lo, 32'd63);

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom);
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'd1;
                2:       ry = 32'hFFFF_FFFF;
                3:       ry = $urandom_range(2, 300);
                default: ry = $urandom;
            endcase
            run_op("rand", ro, rx, ry, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check("done_one_cycle", done, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
